// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO helpers: level width, flag reset values, pointer compares
package fifo_pkg;

    localparam logic EMPTY_RST  = 1'b1;
    localparam logic FULL_RST   = 1'b0;
    localparam logic AEMPTY_RST = 1'b1;
    localparam logic AFULL_RST  = 1'b0;
    localparam logic ERR_RST    = 1'b0;

    // Width of a pointer / level value: one extra wrap bit over the RAM index.
    function automatic int level_width(input int ptr_depth);
        return ptr_depth + 1;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp);
        return wp == rp;
    endfunction

    // Full when only the wrap bit differs.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                      input int unsigned depth);
        return (wp ^ rp) == (32'd1 << depth);
    endfunction

endpackage

// File: rtl/param_fifo_lvl_if.sv
// rtl/param_fifo_lvl_if.sv - FIFO request/status bundle
// master: producer/consumer side (drives flush_in, data_in, wr_in, rd_in)
// slave : FIFO side (drives data_out, full/empty/almost flags, level_out, sticky errors)
interface param_fifo_lvl_if #(
    parameter int FIFO_PTR_DEPTH = 4,
    parameter int DATA_SIZE      = 32
);
    logic                    flush_in;
    logic [DATA_SIZE-1:0]    data_in;
    logic                    wr_in;
    logic                    rd_in;
    logic [DATA_SIZE-1:0]    data_out;
    logic                    fifo_full_out;
    logic                    fifo_empty_out;
    logic                    almost_full_out;
    logic                    almost_empty_out;
    logic [FIFO_PTR_DEPTH:0] level_out;
    logic                    overflow_out;
    logic                    underflow_out;

    modport master (
        output flush_in, data_in, wr_in, rd_in,
        input  data_out, fifo_full_out, fifo_empty_out, almost_full_out, almost_empty_out,
        input  level_out, overflow_out, underflow_out
    );

    modport slave (
        input  flush_in, data_in, wr_in, rd_in,
        output data_out, fifo_full_out, fifo_empty_out, almost_full_out, almost_empty_out,
        output level_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/fifo_fwft_stage.sv
// rtl/fifo_fwft_stage.sv - first-word-fall-through output register (head word + valid)
// in : clk, rst, flush, load (take din from RAM), pop (head consumed), din
// out: valid, data (head word), valid_next (next-state valid, for level accounting)
module fifo_fwft_stage #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 load,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 valid_next,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] data
);
    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] data_q, data_d;

    // A load in the same cycle as a pop refills the stage with the next word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_next = valid_d;
    assign valid      = valid_q;
    assign data       = data_q;
endmodule

// File: rtl/param_fifo_lvl.sv
// rtl/param_fifo_lvl.sv - single-clock FIFO with level, almost flags, flush, sticky errors, optional FWFT
// in : clk, rst (async, active high), bus.slave (flush_in, data_in, wr_in, rd_in)
// out: bus.slave (data_out, fifo_full_out, fifo_empty_out, almost_full_out, almost_empty_out,
//      level_out, overflow_out, underflow_out)
module param_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int FIFO_PTR_DEPTH = 4,
    parameter int DATA_SIZE      = 32,
    parameter int FWFT           = 0,
    parameter int AFULL_THRESH   = 12,
    parameter int AEMPTY_THRESH  = 2
) (
    input logic           clk,
    input logic           rst,
    param_fifo_lvl_if.slave bus
);
    localparam int LW    = level_width(FIFO_PTR_DEPTH);
    localparam int DEPTH = 2 ** FIFO_PTR_DEPTH;

    logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic          ram_empty_q, ram_empty_d, ram_full_q, ram_full_d;
    logic          afull_q, afull_d, aempty_q, aempty_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          fifo_empty, wr_acc, rd_acc, ram_rd, out_valid_d;
    int            level_i;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] ram_rdata;

    assign ram_rdata = mem[rd_ptr_q[FIFO_PTR_DEPTH-1:0]];

    // Acceptance uses registered flags only, so a same-cycle read never unblocks a
    // write on a full FIFO and vice versa.
    assign wr_acc = bus.wr_in & ~ram_full_q;
    assign rd_acc = bus.rd_in & ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + LW'(1);
            if (ram_rd) rd_ptr_d = rd_ptr_q + LW'(1);
        end
        ram_empty_d = ptr_empty(32'(wr_ptr_d), 32'(rd_ptr_d));
        ram_full_d  = ptr_full(32'(wr_ptr_d), 32'(rd_ptr_d), FIFO_PTR_DEPTH);
        // Modular pointer difference is the RAM count; the FWFT head word adds one.
        level_d     = (wr_ptr_d - rd_ptr_d) + LW'(out_valid_d);
        level_i     = int'(level_d);
        afull_d     = level_i >= AFULL_THRESH;
        aempty_d    = level_i <= AEMPTY_THRESH;
        ovf_d       = ovf_q | (bus.wr_in & ram_full_q);
        unf_d       = unf_q | (bus.rd_in & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (wr_acc & ~bus.flush_in) mem[wr_ptr_q[FIFO_PTR_DEPTH-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ram_empty_q <= EMPTY_RST;
            ram_full_q  <= FULL_RST;
            afull_q     <= AFULL_RST;
            aempty_q    <= AEMPTY_RST;
            ovf_q       <= ERR_RST;
            unf_q       <= ERR_RST;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ram_empty_q <= ram_empty_d;
            ram_full_q  <= ram_full_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic                 out_valid;
            logic [DATA_SIZE-1:0] out_data;

            // Refill the head register whenever it is empty or being consumed.
            assign ram_rd = (~out_valid | rd_acc) & ~ram_empty_q & ~bus.flush_in;

            fifo_fwft_stage #(.DATA_SIZE(DATA_SIZE)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (bus.flush_in),
                .load       (ram_rd),
                .pop        (rd_acc),
                .din        (ram_rdata),
                .valid_next (out_valid_d),
                .valid      (out_valid),
                .data       (out_data)
            );

            assign fifo_empty   = ~out_valid;
            assign bus.data_out = out_data;
        end else begin : g_reg
            logic [DATA_SIZE-1:0] data_q, data_d;

            assign ram_rd      = rd_acc & ~bus.flush_in;
            assign fifo_empty  = ram_empty_q;
            assign out_valid_d = 1'b0;

            always_comb begin
                data_d = data_q;
                if (ram_rd) data_d = ram_rdata;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) data_q <= '0;
                else     data_q <= data_d;
            end

            assign bus.data_out = data_q;
        end
    endgenerate

    assign bus.fifo_full_out    = ram_full_q;
    assign bus.fifo_empty_out   = fifo_empty;
    assign bus.almost_full_out  = afull_q;
    assign bus.almost_empty_out = aempty_q;
    assign bus.level_out        = level_q;
    assign bus.overflow_out     = ovf_q;
    assign bus.underflow_out    = unf_q;
endmodule

// File: tb/tb_param_fifo_lvl.sv
// tb/tb_param_fifo_lvl.sv - self-checking bench for param_fifo_lvl (registered and FWFT modes)
module tb_param_fifo_lvl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_fifo_lvl_if #(.FIFO_PTR_DEPTH(4), .DATA_SIZE(32)) b0 ();
    param_fifo_lvl_if #(.FIFO_PTR_DEPTH(4), .DATA_SIZE(32)) b1 ();

    param_fifo_lvl #(
        .FIFO_PTR_DEPTH(4), .DATA_SIZE(32), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    param_fifo_lvl #(
        .FIFO_PTR_DEPTH(4), .DATA_SIZE(32), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] sb1[$];
    logic [31:0] last_rd = '0;
    logic [31:0] exp_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr0(input logic [31:0] d);
        b0.wr_in   = 1'b1;
        b0.data_in = d;
        tick();
        b0.wr_in = 1'b0;
        sb.push_back(d);
    endtask

    task automatic rd0(input string tag);
        b0.rd_in = 1'b1;
        tick();
        b0.rd_in = 1'b0;
        if (sb.size() == 0) exp_v = 'x;
        else                exp_v = sb.pop_front();
        last_rd = exp_v;
        check_eq(tag, b0.data_out, exp_v);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_level"},  32'(b0.level_out), 32'd0);
        check_eq({pfx, "_empty"},  32'(b0.fifo_empty_out), 32'd1);
        check_eq({pfx, "_full"},   32'(b0.fifo_full_out), 32'd0);
        check_eq({pfx, "_aempty"}, 32'(b0.almost_empty_out), 32'd1);
        check_eq({pfx, "_afull"},  32'(b0.almost_full_out), 32'd0);
        check_eq({pfx, "_ovf"},    32'(b0.overflow_out), 32'd0);
        check_eq({pfx, "_unf"},    32'(b0.underflow_out), 32'd0);
        check_eq({pfx, "_data"},   b0.data_out, 32'd0);
        check_eq({pfx, "_f_empty"}, 32'(b1.fifo_empty_out), 32'd1);
        check_eq({pfx, "_f_level"}, 32'(b1.level_out), 32'd0);
        check_eq({pfx, "_f_data"},  b1.data_out, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        b0.flush_in = 1'b0; b0.wr_in = 1'b0; b0.rd_in = 1'b0; b0.data_in = '0;
        b1.flush_in = 1'b0; b1.wr_in = 1'b0; b1.rd_in = 1'b0; b1.data_in = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // 1: fill 0..15 then drain in order
        for (int i = 0; i < 16; i++) begin
            wr0(32'(i));
            check_eq("t1_level", 32'(b0.level_out), 32'(i + 1));
            check_eq("t1_afull", 32'(b0.almost_full_out), 32'((i + 1) >= 12));
            check_eq("t1_full",  32'(b0.fifo_full_out), 32'(i == 15));
        end
        for (int i = 0; i < 16; i++) begin
            rd0("t1_data");
            check_eq("t1_rlevel", 32'(b0.level_out), 32'(15 - i));
            check_eq("t1_empty",  32'(b0.fifo_empty_out), 32'(i == 15));
            check_eq("t1_aempty", 32'(b0.almost_empty_out), 32'((15 - i) <= 2));
        end

        // 2: overflow and underflow
        for (int i = 0; i < 16; i++) wr0(32'h40 + 32'(i));
        b0.wr_in = 1'b1; b0.data_in = 32'hDEAD;
        tick();
        b0.wr_in = 1'b0;
        check_eq("t2_ovf",   32'(b0.overflow_out), 32'd1);
        check_eq("t2_level", 32'(b0.level_out), 32'd16);
        for (int i = 0; i < 16; i++) rd0("t2_data");
        check_eq("t2_ovf_hold", 32'(b0.overflow_out), 32'd1);
        check_eq("t2_unf_pre",  32'(b0.underflow_out), 32'd0);
        b0.rd_in = 1'b1;
        tick();
        b0.rd_in = 1'b0;
        check_eq("t2_unf",   32'(b0.underflow_out), 32'd1);
        check_eq("t2_dhold", b0.data_out, last_rd);
        check_eq("t2_level0", 32'(b0.level_out), 32'd0);

        // 3: level 8, 40 cycles of simultaneous read+write across pointer wraps
        for (int i = 0; i < 8; i++) wr0(32'd100 + 32'(i));
        for (int i = 0; i < 40; i++) begin
            b0.wr_in = 1'b1; b0.rd_in = 1'b1; b0.data_in = 32'd200 + 32'(i);
            tick();
            exp_v = (sb.size() == 0) ? 'x : sb.pop_front();
            last_rd = exp_v;
            check_eq("t3_data", b0.data_out, exp_v);
            sb.push_back(32'd200 + 32'(i));
            check_eq("t3_level", 32'(b0.level_out), 32'd8);
        end
        b0.wr_in = 1'b0; b0.rd_in = 1'b0;
        for (int i = 0; i < 8; i++) rd0("t3_drain");

        // 4: flush with a same-cycle write
        for (int i = 0; i < 5; i++) wr0(32'd300 + 32'(i));
        check_eq("t4_level5", 32'(b0.level_out), 32'd5);
        b0.flush_in = 1'b1; b0.wr_in = 1'b1; b0.data_in = 32'hBEEF;
        tick();
        b0.flush_in = 1'b0; b0.wr_in = 1'b0;
        sb.delete();
        check_eq("t4_level",  32'(b0.level_out), 32'd0);
        check_eq("t4_empty",  32'(b0.fifo_empty_out), 32'd1);
        check_eq("t4_aempty", 32'(b0.almost_empty_out), 32'd1);
        check_eq("t4_dhold",  b0.data_out, last_rd);
        check_eq("t4_ovf",    32'(b0.overflow_out), 32'd1);
        wr0(32'h77);
        rd0("t4_after");
        check_eq("t4_empty2", 32'(b0.fifo_empty_out), 32'd1);

        // 5: FWFT latency and capacity
        b1.wr_in = 1'b1; b1.data_in = 32'hA5;
        tick();
        b1.wr_in = 1'b0;
        sb1.push_back(32'hA5);
        check_eq("t5_empty_c1", 32'(b1.fifo_empty_out), 32'd1);
        check_eq("t5_level_c1", 32'(b1.level_out), 32'd1);
        tick();
        check_eq("t5_empty_c2", 32'(b1.fifo_empty_out), 32'd0);
        check_eq("t5_data",     b1.data_out, 32'hA5);
        for (int i = 1; i < 17; i++) begin
            b1.wr_in = 1'b1; b1.data_in = 32'h500 + 32'(i);
            tick();
            sb1.push_back(32'h500 + 32'(i));
        end
        b1.wr_in = 1'b0;
        check_eq("t5_full",  32'(b1.fifo_full_out), 32'd1);
        check_eq("t5_level", 32'(b1.level_out), 32'd17);
        check_eq("t5_afull", 32'(b1.almost_full_out), 32'd1);
        for (int i = 0; i < 17; i++) begin
            exp_v = (sb1.size() == 0) ? 'x : sb1[0];
            check_eq("t5_head", b1.data_out, exp_v);
            check_eq("t5_valid", 32'(b1.fifo_empty_out), 32'd0);
            b1.rd_in = 1'b1;
            tick();
            b1.rd_in = 1'b0;
            if (sb1.size() != 0) void'(sb1.pop_front());
        end
        check_eq("t5_empty_end", 32'(b1.fifo_empty_out), 32'd1);
        check_eq("t5_level_end", 32'(b1.level_out), 32'd0);
        check_eq("t5_ovf",       32'(b1.overflow_out), 32'd0);

        // 6: async reset mid-burst
        for (int i = 0; i < 12; i++) wr0(32'd600 + 32'(i));
        for (int i = 0; i < 3; i++) rd0("t6_data");
        check_eq("t6_level9", 32'(b0.level_out), 32'd9);
        b0.rd_in = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("t6");
        b0.rd_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
